cache_axi_arbiter: RTL and testbench
====================================

# cache_axi_arbiter

Shares the single AXI4 master port between the instruction cache (line refills only) and the data cache (line refills and dirty-line writebacks). Read-address requests from the two caches are arbitrated round-robin. The granted cache keeps the read channel until the last beat of its burst. The write path carries dcache traffic only and is tracked, so that a refill never overtakes an in-flight writeback to the same line. The block sits between the two cache FSMs and the SoC AXI interconnect.

## Interface
- LINE_BEATS, 16: 32-bit beats per cache line; arlen/awlen = LINE_BEATS-1.
- ID_I, 4'd0: arid for icache requests.
- ID_D, 4'd1: arid/awid for dcache requests.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- i_r_req, i_r_addr[31:0], i_r_data_ready  in: icache refill request.
- i_r_rdy, i_ret_valid, i_ret_last, i_r_data[31:0]  out: icache handshake and returned data.
- d_r_req, d_r_addr[31:0], d_r_data_ready  in: dcache refill request.
- d_r_rdy, d_ret_valid, d_ret_last, d_r_data[31:0]  out: dcache handshake and returned data.
- d_w_req, d_w_addr[31:0]  in: dcache writeback address request.
- d_w_rdy  out: AW handshake to dcache.
- d_w_data_req, d_w_last, d_w_data[31:0], d_w_strb[3:0], d_b_ready  in: dcache W/B signals.
- d_w_data_ready, d_b_valid  out: dcache W/B signals.
- arvalid, araddr[31:0], arlen[7:0], arsize[2:0], arburst[1:0], arid[3:0], rready  out: AXI AR/R channel.
- arready, rvalid, rlast, rid[3:0], rdata[31:0]  in: AXI AR/R channel.
- awvalid, awaddr[31:0], awlen, awsize, awburst, awid, wvalid, wlast, wdata, wstrb, bready  out: AXI AW/W/B channel.
- awready, wready, bvalid  in: AXI AW/W/B channel.
- burst_err  out  1: sticky; rlast disagreed with the beat count.

## Operation
- Read FSM states: R_IDLE, R_AR, R_DATA. State registers: gnt (0 = icache, 1 = dcache), last_gnt, beat_cnt[3:0].
- In R_IDLE a requester is eligible when its req is high and it is not hazard-blocked.
  - If both are eligible, the one with id != last_gnt wins.
  - A single eligible requester wins.
  - On a win: latch its address into araddr, set gnt, go to R_AR.
- R_AR: arvalid = 1. arid is ID_I or ID_D. arlen = LINE_BEATS-1, arsize = 3'b010, arburst = 2'b01.
  - On arvalid&arready: pulse the granted x_r_rdy in the same cycle (combinational), set last_gnt = gnt, clear beat_cnt, go to R_DATA.
- R_DATA passes the R channel through to the granted cache only:
  - x_ret_valid = rvalid, x_ret_last = rlast, x_r_data = rdata, rready = x_r_data_ready.
  - The non-granted cache sees ret_valid = 0.
  - Each rvalid&rready beat increments beat_cnt.
  - On a handshaken beat with rlast: go to R_IDLE.
  - If rlast arrives at beat_cnt != LINE_BEATS-1, or is absent at beat LINE_BEATS-1, set burst_err. The FSM still returns to R_IDLE only on rlast.
- Write tracking is dcache only.
  - awvalid = d_w_req, awaddr = d_w_addr, d_w_rdy = awready. awlen/awsize/awburst are as for reads.
  - W and B channels are wired straight through.
  - wr_busy sets on the AW handshake, latching wr_line = awaddr[31:6]. It clears on bvalid&bready.
- Hazard: a read request is blocked in R_IDLE while addr[31:6] equals the line of a pending write. A write is pending when wr_busy is set (compare wr_line) or awvalid is high (compare d_w_addr[31:6]). The request becomes eligible the cycle after B completes.
- No preemption: a grant is released only by rlast.

## Timing
- Reset values:
  - Read side: state R_IDLE, arvalid 0, araddr 0, gnt 0, last_gnt 0 (so dcache wins the first tie), beat_cnt 0, rready 0, all ret_valid/r_rdy 0.
  - Write side: wr_busy 0, burst_err 0.
- Latency: a req seen in R_IDLE at cycle N drives arvalid at N+1. With arready at N+1, r_rdy pulses at N+1 and the first beat can be accepted at N+2.
- arvalid, once high, holds with stable araddr/arid until arready. A requester dropping req has no effect after the grant.
- The W/B paths add zero latency. AW/W ordering is the dcache's responsibility.
- Reset mid-burst returns all state to reset values immediately. Remaining interconnect beats are not tracked.
- A new arbitration can happen in the cycle after rlast. There is no back-to-back AR in the rlast cycle.

## Test plan
- Icache alone, addr 0x1c000040, arready immediate, 16 beats: arvalid at cycle 1 with arid 0 and arlen 15; i_r_rdy pulses at cycle 1; i_ret_last on beat 16; FSM back in R_IDLE; burst_err = 0.
- Both request in the same cycle out of reset: dcache granted first. After its rlast, icache is granted (round-robin). Repeat with both held: grants alternate D, I, D, I.
- Dcache writeback to line 0x80001000 with B delayed 20 cycles, then d_r_req for 0x80001010: AR is withheld until the cycle after bvalid&bready. A read to 0x80002000 under the same conditions issues immediately.
- rready backpressure: d_r_data_ready toggles every cycle. Each beat is delivered exactly once in order, and d_ret_valid stays 0 to the icache.
- Early rlast on beat 8: burst_err = 1, FSM goes to R_IDLE, burst_err stays set until rst.
- rst asserted mid-burst at beat 5: arvalid, rready, gnt and wr_busy go to 0 asynchronously; the next request arbitrates normally.

Source files
------------

// File: rtl/cache_axi_arbiter.sv
// Shares one AXI4 master port between the icache (refills) and dcache (refills + writebacks).
// Reads are arbitrated round-robin; refills to a line with a pending writeback are held off.
module cache_axi_arbiter #(
    parameter int         LINE_BEATS = 16,
    parameter logic [3:0] ID_I       = 4'd0,
    parameter logic [3:0] ID_D       = 4'd1
) (
    input  logic        clk,
    input  logic        rst,
    // icache refill
    input  logic        i_r_req,
    input  logic [31:0] i_r_addr,
    input  logic        i_r_data_ready,
    output logic        i_r_rdy,
    output logic        i_ret_valid,
    output logic        i_ret_last,
    output logic [31:0] i_r_data,
    // dcache refill
    input  logic        d_r_req,
    input  logic [31:0] d_r_addr,
    input  logic        d_r_data_ready,
    output logic        d_r_rdy,
    output logic        d_ret_valid,
    output logic        d_ret_last,
    output logic [31:0] d_r_data,
    // dcache writeback
    input  logic        d_w_req,
    input  logic [31:0] d_w_addr,
    output logic        d_w_rdy,
    input  logic        d_w_data_req,
    input  logic        d_w_last,
    input  logic [31:0] d_w_data,
    input  logic [3:0]  d_w_strb,
    input  logic        d_b_ready,
    output logic        d_w_data_ready,
    output logic        d_b_valid,
    // AXI AR/R
    output logic        arvalid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [3:0]  arid,
    output logic        rready,
    input  logic        arready,
    input  logic        rvalid,
    input  logic        rlast,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    // AXI AW/W/B
    output logic        awvalid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [3:0]  awid,
    output logic        wvalid,
    output logic        wlast,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        bready,
    input  logic        awready,
    input  logic        wready,
    input  logic        bvalid,
    output logic        burst_err
);

    localparam logic [3:0] LAST_BEAT = 4'(LINE_BEATS - 1);
    localparam logic [7:0] BURST_LEN = 8'(LINE_BEATS - 1);

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_t;

    r_state_t    state_reg, state_next;
    logic        gnt_reg, gnt_next;
    logic        last_gnt_reg, last_gnt_next;
    logic [3:0]  beat_cnt_reg, beat_cnt_next;
    logic [31:0] araddr_reg, araddr_next;
    logic        burst_err_reg, burst_err_next;
    logic        wr_busy_reg;
    logic [25:0] wr_line_reg;

    logic i_blocked, d_blocked, i_elig, d_elig, pick_d, r_hs;
    logic rid_unused;

    // A line is unsafe to refill while its writeback is accepted-but-unacknowledged or still being offered.
    assign i_blocked = (wr_busy_reg && i_r_addr[31:6] == wr_line_reg) ||
                       (d_w_req && i_r_addr[31:6] == d_w_addr[31:6]);
    assign d_blocked = (wr_busy_reg && d_r_addr[31:6] == wr_line_reg) ||
                       (d_w_req && d_r_addr[31:6] == d_w_addr[31:6]);
    assign i_elig = i_r_req && !i_blocked;
    assign d_elig = d_r_req && !d_blocked;
    assign pick_d = (i_elig && d_elig) ? !last_gnt_reg : d_elig;
    assign r_hs   = rvalid && rready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= R_IDLE;
            gnt_reg       <= 1'b0;
            last_gnt_reg  <= 1'b0;
            beat_cnt_reg  <= 4'd0;
            araddr_reg    <= 32'd0;
            burst_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            gnt_reg       <= gnt_next;
            last_gnt_reg  <= last_gnt_next;
            beat_cnt_reg  <= beat_cnt_next;
            araddr_reg    <= araddr_next;
            burst_err_reg <= burst_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        gnt_next       = gnt_reg;
        last_gnt_next  = last_gnt_reg;
        beat_cnt_next  = beat_cnt_reg;
        araddr_next    = araddr_reg;
        burst_err_next = burst_err_reg;
        arvalid        = 1'b0;
        rready         = 1'b0;
        i_r_rdy        = 1'b0;
        d_r_rdy        = 1'b0;
        i_ret_valid    = 1'b0;
        d_ret_valid    = 1'b0;
        i_ret_last     = 1'b0;
        d_ret_last     = 1'b0;
        case (state_reg)
            R_IDLE: begin
                if (i_elig || d_elig) begin
                    gnt_next    = pick_d;
                    araddr_next = pick_d ? d_r_addr : i_r_addr;
                    state_next  = R_AR;
                end
            end
            R_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    i_r_rdy       = !gnt_reg;
                    d_r_rdy       = gnt_reg;
                    last_gnt_next = gnt_reg;
                    beat_cnt_next = 4'd0;
                    state_next    = R_DATA;
                end
            end
            R_DATA: begin
                rready      = gnt_reg ? d_r_data_ready : i_r_data_ready;
                i_ret_valid = !gnt_reg && rvalid;
                d_ret_valid = gnt_reg && rvalid;
                i_ret_last  = !gnt_reg && rlast;
                d_ret_last  = gnt_reg && rlast;
                if (r_hs) begin
                    beat_cnt_next = beat_cnt_reg + 4'd1;
                    // Flags both an early rlast and a missing one on the final counted beat.
                    if (rlast != (beat_cnt_reg == LAST_BEAT))
                        burst_err_next = 1'b1;
                    if (rlast)
                        state_next = R_IDLE;
                end
            end
            default: state_next = R_IDLE;
        endcase
    end

    assign araddr     = araddr_reg;
    assign arid       = gnt_reg ? ID_D : ID_I;
    assign arlen      = BURST_LEN;
    assign arsize     = 3'b010;
    assign arburst    = 2'b01;
    assign i_r_data   = rdata;
    assign d_r_data   = rdata;
    assign burst_err  = burst_err_reg;
    assign rid_unused = ^rid;

    // Write side: dcache only, straight through, with one outstanding line tracked for the hazard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_busy_reg <= 1'b0;
            wr_line_reg <= 26'd0;
        end else if (d_w_req && awready) begin
            wr_busy_reg <= 1'b1;
            wr_line_reg <= d_w_addr[31:6];
        end else if (bvalid && d_b_ready) begin
            wr_busy_reg <= 1'b0;
        end
    end

    assign awvalid        = d_w_req;
    assign awaddr         = d_w_addr;
    assign awlen          = BURST_LEN;
    assign awsize         = 3'b010;
    assign awburst        = 2'b01;
    assign awid           = ID_D;
    assign d_w_rdy        = awready;
    assign wvalid         = d_w_data_req;
    assign wlast          = d_w_last;
    assign wdata          = d_w_data;
    assign wstrb          = d_w_strb;
    assign d_w_data_ready = wready;
    assign bready         = d_b_ready;
    assign d_b_valid      = bvalid;

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Bench for cache_axi_arbiter: table of arbitration vectors plus hand sequences for hazard,
// backpressure, burst errors and reset; returned beats are checked through a scoreboard queue.
module tb_cache_axi_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_r_req, i_r_data_ready, i_r_rdy, i_ret_valid, i_ret_last;
    logic [31:0] i_r_addr, i_r_data;
    logic        d_r_req, d_r_data_ready, d_r_rdy, d_ret_valid, d_ret_last;
    logic [31:0] d_r_addr, d_r_data;
    logic        d_w_req, d_w_rdy, d_w_data_req, d_w_last, d_b_ready, d_w_data_ready, d_b_valid;
    logic [31:0] d_w_addr, d_w_data;
    logic [3:0]  d_w_strb;
    logic        arvalid, rready, arready, rvalid, rlast;
    logic [31:0] araddr, rdata;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [3:0]  arid, rid;
    logic        awvalid, wvalid, wlast, bready, awready, wready, bvalid;
    logic [31:0] awaddr, wdata;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [3:0]  awid, wstrb;
    logic        burst_err;

    cache_axi_arbiter dut (
        .clk(clk), .rst(rst),
        .i_r_req(i_r_req), .i_r_addr(i_r_addr), .i_r_data_ready(i_r_data_ready),
        .i_r_rdy(i_r_rdy), .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last), .i_r_data(i_r_data),
        .d_r_req(d_r_req), .d_r_addr(d_r_addr), .d_r_data_ready(d_r_data_ready),
        .d_r_rdy(d_r_rdy), .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last), .d_r_data(d_r_data),
        .d_w_req(d_w_req), .d_w_addr(d_w_addr), .d_w_rdy(d_w_rdy),
        .d_w_data_req(d_w_data_req), .d_w_last(d_w_last), .d_w_data(d_w_data), .d_w_strb(d_w_strb),
        .d_b_ready(d_b_ready), .d_w_data_ready(d_w_data_ready), .d_b_valid(d_b_valid),
        .arvalid(arvalid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arid(arid), .rready(rready), .arready(arready), .rvalid(rvalid), .rlast(rlast),
        .rid(rid), .rdata(rdata),
        .awvalid(awvalid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awid(awid), .wvalid(wvalid), .wlast(wlast), .wdata(wdata), .wstrb(wstrb), .bready(bready),
        .awready(awready), .wready(wready), .bvalid(bvalid),
        .burst_err(burst_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          dest_d;
        logic [31:0] data;
        bit          last;
    } sb_t;

    typedef struct {
        bit          i_req;
        bit          d_req;
        logic [31:0] i_addr;
        logic [31:0] d_addr;
        bit          exp_d;
        logic [31:0] exp_addr;
        bit          keep;
        int          ar_delay;
    } vec_t;

    sb_t sb[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [31:0] a, input int b);
        return a ^ (32'(b) * 32'h01010101) ^ 32'hA5000000;
    endfunction

    task automatic sb_pop(input bit dest_d, input logic [31:0] data, input bit last);
        sb_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("ret_beat", {dest_d, last, data}, {e.dest_d, e.last, e.data});
            $display("beat to %s data %h last %0b", dest_d ? "D" : "I", data, last);
        end
    endtask

    // A beat counts as delivered when the cache sees valid while it is ready.
    always @(negedge clk) begin
        if (!rst) begin
            if (i_ret_valid && i_r_data_ready) sb_pop(1'b0, i_r_data, i_ret_last);
            if (d_ret_valid && d_r_data_ready) sb_pop(1'b1, d_r_data, d_ret_last);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the last handshaken beat (or after abort_beat beats).
    task automatic do_read(input bit exp_d, input logic [31:0] exp_addr, input int exp_lat,
                           input bit keep, input int ar_delay, input int rlast_beat,
                           input bit toggle, input int abort_beat, input bit exp_err);
        int lat, b, cyc;
        bit hs, tgl;
        sb_t e;
        lat = 0;
        @(negedge clk);
        while (!arvalid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!arvalid) begin
            chk("ar_timeout", 0, 1);
            return;
        end
        chk("ar_latency", lat, exp_lat);
        chk("arid", arid, exp_d ? 1 : 0);
        chk("araddr", araddr, exp_addr);
        chk("arlen_size_burst", {arlen, arsize, arburst}, {8'd15, 3'd2, 2'd1});
        for (int k = 0; k < ar_delay; k++) begin
            if (!keep) begin
                i_r_req = 1'b0;
                d_r_req = 1'b0;
            end
            @(negedge clk);
            chk("ar_hold", {arvalid, araddr}, {1'b1, exp_addr});
        end
        arready = 1'b1;
        #1;
        chk("r_rdy", {i_r_rdy, d_r_rdy}, exp_d ? 2'b01 : 2'b10);
        for (int k = 0; k <= rlast_beat; k++) begin
            e.dest_d = exp_d;
            e.data   = pat(exp_addr, k);
            e.last   = (k == rlast_beat);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        arready = 1'b0;
        chk("arvalid_drop", arvalid, 0);
        if (!keep) begin
            i_r_req = 1'b0;
            d_r_req = 1'b0;
        end
        b = 0;
        cyc = 0;
        tgl = 1'b0;
        while (b <= rlast_beat && cyc < 200) begin
            if (b == abort_beat) return;
            rvalid = 1'b1;
            rdata  = pat(exp_addr, b);
            rlast  = (b == rlast_beat);
            tgl    = toggle ? !tgl : 1'b1;
            i_r_data_ready = exp_d ? 1'b1 : tgl;
            d_r_data_ready = exp_d ? tgl : 1'b1;
            @(negedge clk);
            hs = rready;
            chk("other_ret_valid", exp_d ? i_ret_valid : d_ret_valid, 0);
            @(posedge clk);
            #1;
            if (hs) b++;
            cyc++;
        end
        if (b <= rlast_beat) chk("beat_timeout", 0, 1);
        rvalid = 1'b0;
        rlast  = 1'b0;
        i_r_data_ready = 1'b0;
        d_r_data_ready = 1'b0;
        chk("rready_idle", rready, 0);
        chk("burst_err", burst_err, exp_err);
        $display("read %s addr %h lat %0d done, burst_err %0b", exp_d ? "D" : "I", exp_addr, lat, burst_err);
    endtask

    task automatic aw_write(input logic [31:0] addr);
        d_w_req  = 1'b1;
        d_w_addr = addr;
        awready  = 1'b1;
        @(negedge clk);
        chk("aw_pass", {awvalid, awaddr, d_w_rdy, awid, awlen}, {1'b1, addr, 1'b1, 4'd1, 8'd15});
        @(posedge clk);
        #1;
        d_w_req = 1'b0;
        awready = 1'b0;
        $display("aw addr %h accepted", addr);
    endtask

    task automatic b_complete();
        bvalid    = 1'b1;
        d_b_ready = 1'b1;
        @(negedge clk);
        chk("b_pass", {d_b_valid, bready}, 2'b11);
        @(posedge clk);
        #1;
        bvalid    = 1'b0;
        d_b_ready = 1'b0;
        $display("b response completed");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        bit   seen;
        vecs[0] = '{1, 1, 32'h1c000080, 32'h80000040, 1, 32'h80000040, 1, 0};
        vecs[1] = '{1, 1, 32'h1c000080, 32'h80000040, 0, 32'h1c000080, 1, 0};
        vecs[2] = '{1, 1, 32'h1c000080, 32'h80000040, 1, 32'h80000040, 1, 0};
        vecs[3] = '{1, 1, 32'h1c000080, 32'h80000040, 0, 32'h1c000080, 0, 0};
        vecs[4] = '{1, 0, 32'h1c000040, 32'h00000000, 0, 32'h1c000040, 0, 0};
        vecs[5] = '{0, 1, 32'h00000000, 32'h80000100, 1, 32'h80000100, 0, 3};

        rst = 1'b1;
        i_r_req = 0; i_r_addr = 0; i_r_data_ready = 0;
        d_r_req = 0; d_r_addr = 0; d_r_data_ready = 0;
        d_w_req = 0; d_w_addr = 0; d_w_data_req = 0; d_w_last = 0; d_w_data = 0; d_w_strb = 0;
        d_b_ready = 0;
        arready = 0; rvalid = 0; rlast = 0; rid = 0; rdata = 0;
        awready = 0; wready = 0; bvalid = 0;

        repeat (2) @(negedge clk);
        chk("reset_outputs", {arvalid, rready, i_r_rdy, d_r_rdy, i_ret_valid, d_ret_valid, burst_err, awvalid},
            8'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Arbitration vectors: tie out of reset goes to dcache, then alternates while both are held.
        for (int v = 0; v < 6; v++) begin
            i_r_req  = vecs[v].i_req;
            d_r_req  = vecs[v].d_req;
            i_r_addr = vecs[v].i_addr;
            d_r_addr = vecs[v].d_addr;
            do_read(vecs[v].exp_d, vecs[v].exp_addr, 1, vecs[v].keep, vecs[v].ar_delay, 15, 0, -1, 0);
        end

        // W channel pass-through.
        d_w_data_req = 1'b1; d_w_last = 1'b1; d_w_data = 32'hdeadbeef; d_w_strb = 4'h5; wready = 1'b1;
        #1;
        chk("w_pass", {wvalid, wlast, wdata, wstrb, d_w_data_ready}, {1'b1, 1'b1, 32'hdeadbeef, 4'h5, 1'b1});
        d_w_data_req = 1'b0; d_w_last = 1'b0; d_w_data = 0; d_w_strb = 0; wready = 1'b0;

        // Refill to a line with an outstanding writeback waits for B.
        aw_write(32'h80001000);
        d_r_req  = 1'b1;
        d_r_addr = 32'h80001010;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (arvalid) seen = 1'b1;
        end
        chk("hazard_hold", seen, 0);
        @(posedge clk);
        #1;
        b_complete();
        do_read(1, 32'h80001010, 1, 0, 0, 15, 0, -1, 0);

        // Different line under the same conditions issues at once.
        aw_write(32'h80001000);
        d_r_req  = 1'b1;
        d_r_addr = 32'h80002000;
        do_read(1, 32'h80002000, 1, 0, 0, 15, 0, -1, 0);
        b_complete();

        // Backpressure on the dcache side.
        d_r_req  = 1'b1;
        d_r_addr = 32'h80004000;
        do_read(1, 32'h80004000, 1, 0, 0, 15, 1, -1, 0);

        // Early rlast on beat 8, then a clean burst: the error stays.
        i_r_req  = 1'b1;
        i_r_addr = 32'h1c000200;
        do_read(0, 32'h1c000200, 1, 0, 0, 7, 0, -1, 1);
        d_r_req  = 1'b1;
        d_r_addr = 32'h80005000;
        do_read(1, 32'h80005000, 1, 0, 0, 15, 0, -1, 1);

        // Reset in the middle of a burst with a writeback outstanding.
        aw_write(32'h80003000);
        i_r_req  = 1'b1;
        i_r_addr = 32'h1c000300;
        do_read(0, 32'h1c000300, 1, 0, 0, 15, 0, 5, 0);
        #1;
        rst = 1'b1;
        #1;
        chk("async_reset", {arvalid, rready, i_ret_valid, d_ret_valid, burst_err}, 5'd0);
        $display("reset asserted mid-burst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        rvalid = 1'b0; rlast = 1'b0; i_r_req = 1'b0;
        i_r_data_ready = 1'b0; d_r_data_ready = 1'b0;
        sb.delete();
        d_r_req  = 1'b1;
        d_r_addr = 32'h80003000;
        do_read(1, 32'h80003000, 1, 0, 0, 15, 0, -1, 0);

        repeat (2) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
